mac_int_accum_pipe: RTL and testbench

//  Parametrised LANES-wide packed-integer dot-product/accumulate engine; successor of the single-shot integer MAC path.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_lane_dot.sv | 52 +++++
 rtl/mac_int_accum_pipe.sv | 189 ++++++++++++++++++
 tb/tb_mac_int_accum_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the packed-integer MAC/accumulate pipeline.
//   mac_mode_e  : operand packing selector (int4 x8, int8 x4, int16 x2; 2'b11 behaves as int8)
//   mac_state_e : group-tracking FSM states
//   DOT_W       : width of one lane's sum of sub-products (int16 x2 can reach +2^31)
package mac_pkg;

  localparam int DOT_W = 33;

  typedef enum logic [1:0] {
    MAC_I4X8  = 2'b00,
    MAC_I8X4  = 2'b01,
    MAC_I16X2 = 2'b10
  } mac_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } mac_state_e;

endpackage

// File: rtl/mac_lane_dot.sv
// Combinational per-lane dot product of two packed signed 32-bit words.
// Ports:
//   mode [1:0]      packing: 00 int4 x8, 01 int8 x4, 10 int16 x2, 11 treated as int8
//   a, b [31:0]     packed signed operands, element i at the i-th field from bit 0
//   dot  [DOT_W-1:0] signed sum of the element-wise products
module mac_lane_dot
  import mac_pkg::*;
(
  input  logic [1:0]       mode,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output logic [DOT_W-1:0] dot
);

  // Operands are sign-extended to the product width so every multiply is
  // same-width; the true products always fit (e.g. (-128)^2 = 16384 < 2^15).
  logic signed [7:0]  p4  [8];
  logic signed [15:0] p8  [4];
  logic signed [31:0] p16 [2];
  logic [DOT_W-1:0]   s4, s8, s16;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_i4
      assign p4[gi] = $signed({{4{a[4*gi+3]}}, a[4*gi +: 4]}) *
                      $signed({{4{b[4*gi+3]}}, b[4*gi +: 4]});
    end
    for (gi = 0; gi < 4; gi++) begin : g_i8
      assign p8[gi] = $signed({{8{a[8*gi+7]}}, a[8*gi +: 8]}) *
                      $signed({{8{b[8*gi+7]}}, b[8*gi +: 8]});
    end
    for (gi = 0; gi < 2; gi++) begin : g_i16
      assign p16[gi] = $signed({{16{a[16*gi+15]}}, a[16*gi +: 16]}) *
                       $signed({{16{b[16*gi+15]}}, b[16*gi +: 16]});
    end
  endgenerate

  always_comb begin
    s4  = '0;
    s8  = '0;
    s16 = '0;
    for (int i = 0; i < 8; i++) s4  = s4  + {{(DOT_W-8){p4[i][7]}}, p4[i]};
    for (int i = 0; i < 4; i++) s8  = s8  + {{(DOT_W-16){p8[i][15]}}, p8[i]};
    for (int i = 0; i < 2; i++) s16 = s16 + {{(DOT_W-32){p16[i][31]}}, p16[i]};
    case (mode)
      MAC_I4X8:  dot = s4;
      MAC_I16X2: dot = s16;
      default:   dot = s8;
    endcase
  end

endmodule

// File: rtl/mac_int_accum_pipe.sv
// LANES-wide packed-integer dot-product/accumulate engine with valid/ready
// handshakes. Each accepted beat forms a per-lane dot product (stage 1), which
// is added to a running accumulator seeded from a per-lane bias (stage 2).
// After cfg_k beats the accumulators are published on out_data.
// Optional feature: define MAC_ACC_SAT_EN to saturate overflowing lanes
// instead of wrapping; ovf_o is raised in both builds.
// Ports:
//   clk, rst (async, active-low)
//   cfg_mode[1:0], cfg_k[CNT_W-1:0]  group config, sampled on a group's first beat
//   in_valid/in_ready, in_a, in_b    operand beat (lane i at [32i+:32])
//   in_c                              per-lane bias, used on the first beat only
//   out_valid/out_ready, out_data     per-lane result (lane i at [ACC_W*i+:ACC_W])
//   busy                              group open or data in flight
//   ovf_o                             sticky signed-overflow flag
module mac_int_accum_pipe
  import mac_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACC_W = 32,
  parameter int K_MAX = 16,
  parameter int CNT_W = $clog2(K_MAX+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             cfg_mode,
  input  logic [CNT_W-1:0]       cfg_k,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*32-1:0]    in_a,
  input  logic [LANES*32-1:0]    in_b,
  input  logic [LANES*ACC_W-1:0] in_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_data,
  output logic                   busy,
  output logic                   ovf_o
);

  // One guard bit above the wider addend makes the exact sum representable.
  localparam int SUM_W = ((ACC_W > DOT_W) ? ACC_W : DOT_W) + 1;

  mac_state_e             state_reg, state_next;
  logic [1:0]             mode_lat_reg;
  logic [CNT_W-1:0]       k_lat_reg, cnt_reg;
  logic                   s1_valid_reg, s1_first_reg, s1_last_reg;
  logic [DOT_W-1:0]       s1_dot_reg  [LANES];
  logic [ACC_W-1:0]       s1_bias_reg [LANES];
  logic [ACC_W-1:0]       acc_reg     [LANES];
  logic [LANES*ACC_W-1:0] out_data_reg;
  logic                   out_valid_reg, ovf_reg;

  logic                   en, accept, beat_first, beat_last;
  logic [1:0]             beat_mode;
  logic [CNT_W-1:0]       k_in, beat_k, cnt_inc;
  logic [DOT_W-1:0]       dot_w    [LANES];
  logic [ACC_W-1:0]       acc_next [LANES];
  logic [LANES-1:0]       lane_ovf;
  logic [LANES*ACC_W-1:0] acc_next_flat;

  // The whole pipeline advances only when the output register can move.
  assign en     = !(out_valid_reg && !out_ready);
  assign accept = in_valid && in_ready;

  always_comb begin
    k_in = cfg_k;
    if (cfg_k == '0)                   k_in = CNT_W'(1);
    else if (cfg_k > CNT_W'(K_MAX))    k_in = CNT_W'(K_MAX);
  end

  // The first beat of a group uses the live config; later beats use the
  // latched copy so config changes mid-group have no effect.
  assign beat_first = (state_reg == ST_IDLE);
  assign beat_mode  = beat_first ? cfg_mode : mode_lat_reg;
  assign beat_k     = beat_first ? k_in : k_lat_reg;
  assign cnt_inc    = beat_first ? CNT_W'(1) : cnt_reg + CNT_W'(1);
  assign beat_last  = (cnt_inc == beat_k);

  // ---------------- group FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (accept) state_next = beat_last ? ST_IDLE : ST_ACCUM;
  end

  always_comb begin
    in_ready = rst && en;
    busy     = (state_reg == ST_ACCUM) || s1_valid_reg || out_valid_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_lat_reg <= '0;
      k_lat_reg    <= '0;
      cnt_reg      <= '0;
    end else if (accept) begin
      if (beat_first) begin
        mode_lat_reg <= cfg_mode;
        k_lat_reg    <= k_in;
      end
      cnt_reg <= beat_last ? '0 : cnt_inc;
    end
  end

  // ---------------- stage 1: dot products ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_first_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        s1_dot_reg[l]  <= '0;
        s1_bias_reg[l] <= '0;
      end
    end else if (en) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_first_reg <= beat_first;
        s1_last_reg  <= beat_last;
        for (int l = 0; l < LANES; l++) begin
          s1_dot_reg[l] <= dot_w[l];
          if (beat_first) s1_bias_reg[l] <= in_c[l*ACC_W +: ACC_W];
        end
      end
    end
  end

  // ---------------- per-lane datapath ----------------
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [ACC_W-1:0] base;
      logic [SUM_W-1:0] sum_full;

      mac_lane_dot u_dot (
        .mode (beat_mode),
        .a    (in_a[32*gi +: 32]),
        .b    (in_b[32*gi +: 32]),
        .dot  (dot_w[gi])
      );

      assign base     = s1_first_reg ? s1_bias_reg[gi] : acc_reg[gi];
      assign sum_full = {{(SUM_W-ACC_W){base[ACC_W-1]}}, base} +
                        {{(SUM_W-DOT_W){s1_dot_reg[gi][DOT_W-1]}}, s1_dot_reg[gi]};
      // Exact sum fits signed ACC_W only if all bits above ACC_W-2 agree.
      assign lane_ovf[gi] = (sum_full[SUM_W-1:ACC_W-1] !=
                             {(SUM_W-ACC_W+1){sum_full[ACC_W-1]}});
`ifdef MAC_ACC_SAT_EN
      assign acc_next[gi] = !lane_ovf[gi]       ? sum_full[ACC_W-1:0] :
                            sum_full[SUM_W-1]   ? {1'b1, {(ACC_W-1){1'b0}}} :
                                                  {1'b0, {(ACC_W-1){1'b1}}};
`else
      assign acc_next[gi] = sum_full[ACC_W-1:0];
`endif
      assign acc_next_flat[gi*ACC_W +: ACC_W] = acc_next[gi];
    end
  endgenerate

  // ---------------- stage 2: accumulate and publish ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < LANES; l++) acc_reg[l] <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (en) begin
      if (s1_valid_reg) begin
        for (int l = 0; l < LANES; l++) acc_reg[l] <= acc_next[l];
        if (|lane_ovf) ovf_reg <= 1'b1;
      end
      // With en high any held result is being taken this edge, so the
      // register either reloads with a new result or empties.
      if (s1_valid_reg && s1_last_reg) begin
        out_data_reg  <= acc_next_flat;
        out_valid_reg <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign ovf_o     = ovf_reg;

endmodule

// File: tb/tb_mac_int_accum_pipe.sv
module tb_mac_int_accum_pipe;
  localparam int LANES = 4;
  localparam int ACC_W = 32;
  localparam int K_MAX = 16;
  localparam int CNT_W = $clog2(K_MAX+1);
  localparam int DW    = LANES*ACC_W;
  localparam longint AMAX = (64'sd1 <<< 31) - 1;
  localparam longint AMIN = -(64'sd1 <<< 31);

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [1:0]             cfg_mode = '0;
  logic [CNT_W-1:0]       cfg_k = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [LANES*32-1:0]    in_a = '0;
  logic [LANES*32-1:0]    in_b = '0;
  logic [DW-1:0]          in_c = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [DW-1:0]          out_data;
  logic                   busy;
  logic                   ovf_o;

  mac_int_accum_pipe #(.LANES(LANES), .ACC_W(ACC_W), .K_MAX(K_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_k(cfg_k),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [DW-1:0] data; bit ovf; } exp_t;
  exp_t    exp_q[$];
  bit      m_in_grp = 0;
  bit      m_ovf = 0;
  int      m_k, m_cnt;
  logic [1:0] m_mode;
  int      m_acc [LANES];
  bit      stall_hold = 0;
  logic [DW-1:0] held_data;

  function automatic longint model_dot(logic [31:0] a, logic [31:0] b, logic [1:0] mode);
    int w, n;
    longint sum, fa, fb;
    w = (mode == 2'b00) ? 4 : (mode == 2'b10) ? 16 : 8;
    n = 32 / w;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      fa = longint'((a >> (i*w)) & 32'((64'd1 << w) - 1));
      fb = longint'((b >> (i*w)) & 32'((64'd1 << w) - 1));
      if (fa >= (longint'(1) << (w-1))) fa = fa - (longint'(1) << w);
      if (fb >= (longint'(1) << (w-1))) fb = fb - (longint'(1) << w);
      sum = sum + fa * fb;
    end
    return sum;
  endfunction

  task automatic model_beat();
    longint s, base;
    bit ov;
    logic [31:0] r;
    logic [DW-1:0] d;
    if (!m_in_grp) begin
      m_mode = cfg_mode;
      m_k    = (cfg_k == 0) ? 1 : ((int'(cfg_k) > K_MAX) ? K_MAX : int'(cfg_k));
      m_cnt  = 0;
    end
    for (int l = 0; l < LANES; l++) begin
      base = m_in_grp ? longint'(m_acc[l]) : longint'($signed(in_c[l*32 +: 32]));
      s  = base + model_dot(in_a[l*32 +: 32], in_b[l*32 +: 32], m_mode);
      ov = (s > AMAX) || (s < AMIN);
      if (ov) m_ovf = 1;
`ifdef MAC_ACC_SAT_EN
      r = ov ? ((s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000) : s[31:0];
`else
      r = s[31:0];
`endif
      m_acc[l] = $signed(r);
      d[l*32 +: 32] = r;
    end
    m_cnt++;
    if (m_cnt == m_k) begin
      exp_q.push_back('{data: d, ovf: m_ovf});
      m_in_grp = 0;
    end else begin
      m_in_grp = 1;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_in_grp   = 0;
      m_ovf      = 0;
      stall_hold = 0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", DW'(out_valid), DW'(0));
        end else begin
          chk("out_data", out_data, exp_q[0].data);
          chk("ovf_o", DW'(ovf_o), DW'(exp_q[0].ovf));
          if (stall_hold) chk("stall_stable", out_data, held_data);
          $display("xfer t=%0t data=%h ready=%0b", $time, out_data, out_ready);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_xfer++;
            stall_hold = 0;
          end else begin
            stall_hold = 1;
            held_data  = out_data;
          end
        end
      end else if (stall_hold) begin
        chk("stall_drop", DW'(out_valid), DW'(1));
        stall_hold = 0;
      end
      chk("in_ready", DW'(in_ready), DW'(!(out_valid && !out_ready)));
      if (in_valid && in_ready) model_beat();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic beat(input logic [1:0] m, input int k, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c);
    bit got;
    in_valid = 1'b1;
    cfg_mode = m;
    cfg_k    = CNT_W'(k);
    in_a     = {LANES{a}};
    in_b     = {LANES{b}};
    in_c     = {LANES{c}};
    got = 0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) chk("beat_timeout", DW'(got), DW'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [DW-1:0] d);
    bit got;
    got = 0;
    d = '0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; d = out_data; end
    end
    if (!got) chk("out_timeout", DW'(got), DW'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic rand_phase(input bit full, input int cycles);
    logic [1:0] m;
    for (int i = 0; i < cycles; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      if (full) m = 2'($urandom_range(0, 3));
      else begin
        m = 2'($urandom_range(0, 2));
        if (m == 2'b10) m = 2'b11;
      end
      cfg_mode = m;
      cfg_k    = CNT_W'($urandom_range(0, 20));
      for (int l = 0; l < LANES; l++) begin
        in_a[l*32 +: 32] = $urandom;
        in_b[l*32 +: 32] = $urandom;
        in_c[l*32 +: 32] = full ? $urandom : 32'($urandom_range(0, 2097152) - 1048576);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  logic [DW-1:0] d;
  int x0;
  logic [31:0] ovf_lane;

  initial begin
    // Reset with a pending beat: nothing may be accepted.
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", DW'(in_ready), DW'(0));
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_ovf", DW'(ovf_o), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_out_data", out_data, DW'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", DW'(in_ready), DW'(1));
    @(posedge clk); #1;

    // int8, k=1: 4*(2*2) + 10 = 26, visible after edge E+1.
    beat(2'b01, 1, 32'h0202_0202, 32'h0202_0202, 32'd10);
    @(negedge clk);
    chk("lat_e", DW'(out_valid), DW'(0));
    @(negedge clk);
    chk("lat_e1", DW'(out_valid), DW'(1));
    chk("i8_k1", out_data, {LANES{32'd26}});
    @(posedge clk); #1;

    // int8, k=3: 3*4*127*127 = 193548.
    repeat (3) beat(2'b01, 3, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'd0);
    wait_out(d);
    chk("i8_k3", d, {LANES{32'd193548}});

    // int4, k=4: 5 + 4*8*(-1) = -27; bias on later beats must be ignored.
    beat(2'b00, 4, 32'hFFFF_FFFF, 32'h1111_1111, 32'd5);
    repeat (3) beat(2'b00, 4, 32'hFFFF_FFFF, 32'h1111_1111, $urandom);
    wait_out(d);
    chk("i4_k4", d, {LANES{32'hFFFF_FFE5}});
    chk("no_ovf_yet", DW'(ovf_o), DW'(0));

    // Backpressure: two k=2 groups (8 then 49), output held for several cycles.
    x0 = n_xfer;
    fork
      begin
        beat(2'b01, 2, 32'h0101_0101, 32'h0101_0101, 32'd0);
        beat(2'b01, 2, 32'h0101_0101, 32'h0101_0101, 32'd0);
        beat(2'b01, 2, 32'h0202_0202, 32'h0303_0303, 32'd1);
        beat(2'b01, 2, 32'h0202_0202, 32'h0303_0303, 32'd1);
      end
      begin
        bit got;
        got = 0;
        for (int t = 0; t < 50 && !got; t++) begin
          @(posedge clk); #1;
          got = out_valid;
        end
        out_ready = 1'b0;
        chk("bp_seen", DW'(got), DW'(1));
        chk("bp_first", out_data, {LANES{32'd8}});
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", DW'(in_ready), DW'(0));
          chk("bp_hold", out_data, {LANES{32'd8}});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 50 && !got; t++) begin
          @(posedge clk); #1;
          got = out_valid && (out_data == {LANES{32'd49}});
        end
        chk("bp_second", DW'(got), DW'(1));
      end
    join
    drain();
    chk("bp_count", DW'(n_xfer - x0), DW'(2));

    // cfg_k raised mid-group is ignored: 3 + 4 + 4 = 11 after two beats.
    beat(2'b01, 2, 32'h0101_0101, 32'h0101_0101, 32'd3);
    beat(2'b01, 8, 32'h0101_0101, 32'h0101_0101, 32'd0);
    wait_out(d);
    chk("k_change", d, {LANES{32'd11}});

    // Reset after first beat of a group: partial result is dropped.
    x0 = n_xfer;
    beat(2'b01, 4, 32'h0101_0101, 32'h0101_0101, 32'd7);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", DW'(busy), DW'(0));
    chk("mid_rst_in_ready", DW'(in_ready), DW'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_out", DW'(out_valid), DW'(0));
    chk("mid_rst_count", DW'(n_xfer - x0), DW'(0));
    @(posedge clk); #1;

    // int16, k=1: 2 * (-32768)^2 = 2^31 overflows signed 32.
`ifdef MAC_ACC_SAT_EN
    ovf_lane = 32'h7FFF_FFFF;
`else
    ovf_lane = 32'h8000_0000;
`endif
    beat(2'b10, 1, 32'h8000_8000, 32'h8000_8000, 32'd0);
    wait_out(d);
    chk("i16_ovf_data", d, {LANES{ovf_lane}});
    chk("i16_ovf_flag", DW'(ovf_o), DW'(1));

    // Only reset clears the sticky flag.
    rst = 1'b0;
    @(negedge clk);
    chk("ovf_clear", DW'(ovf_o), DW'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Random traffic, first without overflow-capable operands, then fully random.
    rand_phase(1'b0, 1200);
    drain();
    chk("rand_a_ovf", DW'(ovf_o), DW'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rand_phase(1'b1, 1200);
    drain();
    chk("drain_empty", DW'(exp_q.size()), DW'(0));
    chk("drain_out_valid", DW'(out_valid), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
